fine_code_slew_dither: RTL

Consumer end of the fine-frequency tracking loop's `osc_fine_con` bus. It latches each committed 8-bit fine code and slews the applied code toward it one LSB at a time, so the oscillator never sees a multi-step jump. It converts the applied code into a 16-cell thermometer enable for the oscillator's fine capacitor bank. The upper 4 bits drive thermometer cells; the lower 4 bits are first-order sigma-delta dithered onto one extra cell. The block sits between the tracking loop and the oscillator core, clocked by the reference clock.

---
 rtl/fftl_pkg.sv | 16 +
 rtl/sd1_therm_enc.sv | 32 +++
 rtl/fine_code_slew_dither.sv | 73 +++++++
 3 files changed

// File: rtl/fftl_pkg.sv
// fftl_pkg: shared types and constants for the fine-frequency tracking loop
package fftl_pkg;

    typedef enum logic [1:0] {IDLE, SLEW, DONE} state_t;

    localparam logic [7:0] FINE_CODE_MID = 8'h80;
    localparam int FINE_CELLS = 16;

    function automatic logic [FINE_CELLS-1:0] therm_of(input logic [4:0] n);
        logic [FINE_CELLS:0] t;
        t = {{FINE_CELLS{1'b0}}, 1'b1} << n;
        t = t - 1'b1;
        return t[FINE_CELLS-1:0];
    endfunction

endpackage

// File: rtl/sd1_therm_enc.sv
// sd1_therm_enc: first-order sigma-delta on the low nibble plus thermometer encoder
module sd1_therm_enc
    import fftl_pkg::*;
(
    input  logic                  ref_clk,
    input  logic                  rst_n,
    input  logic [7:0]            code,
    output logic [FINE_CELLS-1:0] therm
);

    logic [3:0] acc;
    logic [4:0] sum;
    logic [4:0] count;

    // accumulator carry adds one extra cell on top of the upper nibble
    always_comb begin
        sum   = {1'b0, acc} + {1'b0, code[3:0]};
        count = {1'b0, code[7:4]} + {4'b0, sum[4]};
    end

    // accumulator and registered cell enables
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            therm <= 16'h00FF;
        end else begin
            acc   <= sum[3:0];
            therm <= therm_of(count);
        end
    end

endmodule

// File: rtl/fine_code_slew_dither.sv
// fine_code_slew_dither: slews the applied fine code toward the latched target and dithers it onto the cell bank
module fine_code_slew_dither
    import fftl_pkg::*;
#(
    parameter int CODE_W   = 8,
    parameter int SLEW_DIV = 4
) (
    input  logic                  ref_clk,
    input  logic                  rst_n,
    input  logic [CODE_W-1:0]     code_in,
    input  logic                  code_valid,
    input  logic                  hold,
    output logic [FINE_CELLS-1:0] therm_out,
    output logic [CODE_W-1:0]     code_applied,
    output logic                  busy,
    output logic                  settled
);

    state_t            state, state_nx;
    logic [CODE_W-1:0] target, target_nx, applied, applied_nx, stepped;
    logic [7:0]        div_cnt, div_nx;
    logic              tick;

    // next-state: retarget, divider cadence and the single-LSB step
    always_comb begin
        target_nx  = code_valid ? code_in : target;
        tick       = (state == SLEW) && !hold && (div_cnt == 8'(SLEW_DIV - 1));
        stepped    = (target_nx > applied) ? applied + 1'b1 : applied - 1'b1;
        state_nx   = state;
        applied_nx = applied;
        div_nx     = div_cnt;
        if (state != SLEW) begin
            div_nx   = '0;
            state_nx = (code_valid && code_in != applied) ? SLEW : IDLE;
        end else if (code_valid && code_in == applied) begin
            div_nx   = '0;
            state_nx = DONE;
        end else if (!hold) begin
            div_nx = tick ? '0 : div_cnt + 8'd1;
            if (tick) begin
                applied_nx = stepped;
                state_nx   = (stepped == target_nx) ? DONE : SLEW;
            end
        end
    end

    // state registers
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            target  <= FINE_CODE_MID;
            applied <= FINE_CODE_MID;
            div_cnt <= '0;
        end else begin
            state   <= state_nx;
            target  <= target_nx;
            applied <= applied_nx;
            div_cnt <= div_nx;
        end
    end

    assign code_applied = applied;
    assign busy         = (state == SLEW);
    assign settled      = (state == DONE);

    sd1_therm_enc u_enc (
        .ref_clk (ref_clk),
        .rst_n   (rst_n),
        .code    (applied),
        .therm   (therm_out)
    );

endmodule
